// File: rtl/raizing_snd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : raizing_snd_pkg                                           |
// | Purpose  : Shared types and helpers for the Raizing sound ROM path.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package raizing_snd_pkg;

  // Router access phases: decode, stale-OK guard, wait for OK, result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raizing_pcm_bank_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : raizing_pcm_bank_router                                   |
// | Purpose  : Routes PCM byte fetches to NBANK SDRAM ROM slots with     |
// |            out-of-range fill, stale-OK guard, timeout and a          |
// |            one-entry repeat-address cache.                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module raizing_pcm_bank_router
  import raizing_snd_pkg::*;
#(
  parameter int NBANK    = 3,
  parameter int BSEL_W   = 2,
  parameter int BANK_AW  = 22,
  parameter int DW       = 8,
  parameter int OOR_DATA = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     RD,
  input  logic [BSEL_W+BANK_AW-1:0] ADDR,
  output logic [DW-1:0]            DOUT,
  output logic                     VALID,
  output logic                     BUSY,
  output logic                     TIMEOUT_ERR,
  output logic [NBANK-1:0]         BANK_CS,
  output logic [NBANK*BANK_AW-1:0] BANK_ADDR,
  input  logic [NBANK*DW-1:0]      BANK_DOUT,
  input  logic [NBANK-1:0]         BANK_OK
);

  localparam int              c_aw       = BSEL_W + BANK_AW;
  localparam int              c_cnt_w    = clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]   c_oor_data = DW'(OOR_DATA);
  localparam logic            c_to_en    = (TIMEOUT != 0);
  // Terminal count; irrelevant (and masked by c_to_en) when TIMEOUT is 0.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [BSEL_W:0] c_nbank    = (BSEL_W + 1)'(NBANK);

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [BSEL_W-1:0]               w_bank;
  logic [BANK_AW-1:0]              w_local;
  logic                            w_oor;
  logic                            w_hit;
  logic                            w_ok;
  logic                            w_term;
  logic [DW-1:0]                   w_bank_data;

  logic [BSEL_W-1:0]               r_bank;
  logic [c_aw-1:0]                 r_addr;
  logic [c_aw-1:0]                 r_cache_addr;
  logic [DW-1:0]                   r_cache_data;
  logic                            r_cache_valid;
  logic [DW-1:0]                   r_dout;
  logic                            r_err;
  logic [NBANK-1:0]                r_cs;
  logic [NBANK-1:0][BANK_AW-1:0]   r_bank_addr;
  logic [c_cnt_w-1:0]              r_cnt;

  // Address decode of the live request; only consulted in IDLE.
  assign w_bank  = ADDR[c_aw-1:BANK_AW];
  assign w_local = ADDR[BANK_AW-1:0];
  assign w_oor   = ({1'b0, w_bank} >= c_nbank);
  assign w_hit   = r_cache_valid && (ADDR == r_cache_addr);
  assign w_term  = c_to_en && (r_cnt == c_cnt_last);

  // Select OK and data of the bank latched for the access in flight.
  always_comb begin
    w_ok        = 1'b0;
    w_bank_data = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (r_bank == BSEL_W'(i)) begin
        w_ok        = BANK_OK[i];
        w_bank_data = BANK_DOUT[i*DW +: DW];
      end
    end
  end

  // Access phase register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next phase; OK takes priority over the timeout terminal count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (RD) w_state_nxt = (w_hit || w_oor) ? DONE : GUARD;
      GUARD:   w_state_nxt = WAIT;
      WAIT:    if (w_ok || w_term) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, chip selects, held bank addresses, result, cache.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bank        <= '0;
      r_addr        <= '0;
      r_cache_addr  <= '0;
      r_cache_data  <= '0;
      r_cache_valid <= 1'b0;
      r_dout        <= '0;
      r_err         <= 1'b0;
      r_cs          <= '0;
      r_bank_addr   <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (RD) begin
            r_addr <= ADDR;
            r_bank <= w_bank;
            if (w_hit) begin
              r_dout <= r_cache_data;
            end else if (w_oor) begin
              r_dout <= c_oor_data;
            end else begin
              for (int i = 0; i < NBANK; i++) begin
                if (w_bank == BSEL_W'(i)) begin
                  r_cs[i]        <= 1'b1;
                  r_bank_addr[i] <= w_local;
                end
              end
            end
          end
        end
        // OK is deliberately not looked at here: it may still belong to the
        // previous address the bank was serving.
        GUARD: r_cnt <= '0;
        WAIT: begin
          if (w_ok) begin
            r_dout        <= w_bank_data;
            r_cache_addr  <= r_addr;
            r_cache_data  <= w_bank_data;
            r_cache_valid <= 1'b1;
            r_cs          <= '0;
          end else if (w_term) begin
            r_dout <= c_oor_data;
            r_err  <= 1'b1;
            r_cs   <= '0;
          end else if (c_to_en) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign DOUT        = r_dout;
  assign VALID       = (r_state == DONE);
  assign BUSY        = (r_state != IDLE);
  assign TIMEOUT_ERR = r_err;
  assign BANK_CS     = r_cs;
  assign BANK_ADDR   = r_bank_addr;

endmodule
`default_nettype wire

// File: doc/raizing_pcm_bank_router.md
# raizing_pcm_bank_router

Parametrised sample-ROM request router between a PCM sound chip's byte-fetch port (YMZ280B-class, level-held read with valid return) and NBANK independent SDRAM ROM slots. It decodes the flat sample address into a bank select and a bank-local address, and drives exactly one bank chip-select with a registered request/ok handshake. Each bank's address is held between accesses. It adds what the fixed three-slot decode lacked: out-of-range fill, a stale-OK guard cycle, a per-access timeout with a sticky error, and a one-entry repeat-address cache.

## Interface
- NBANK, 3: number of ROM banks (1..8).
- BSEL_W, 2: bank-select bits; must satisfy 2**BSEL_W >= NBANK.
- BANK_AW, 22: bank-local address width.
- DW, 8: data width.
- OOR_DATA, 0: value returned for out-of-range or timed-out reads.
- TIMEOUT, 255: maximum wait cycles for OK; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  reset, asynchronous and active-high.
- RD  in  1  read request, level; held by the requester until VALID.
- ADDR  in  BSEL_W+BANK_AW  flat sample address; ADDR[BSEL_W+BANK_AW-1:BANK_AW] selects the bank.
- DOUT  out  DW  returned data; held until the next VALID.
- VALID  out  1  one-cycle pulse, DOUT valid.
- BUSY  out  1  high while an access is in flight.
- TIMEOUT_ERR  out  1  sticky; set on any timeout, cleared only by RESET.
- BANK_CS  out  NBANK  one-hot-or-zero chip selects.
- BANK_ADDR  out  NBANK*BANK_AW  per-bank address; slice i belongs to bank i.
- BANK_DOUT  in  NBANK*DW  per-bank data.
- BANK_OK  in  NBANK  per-bank data-ready.

## Operation
- The FSM has four states: IDLE, GUARD, WAIT and DONE.
- **IDLE, RD=1:** latch ADDR and decode bank b.
  - Cache hit (cache valid and ADDR equals the cached address): DOUT <= cached data, go to DONE. No CS is driven.
  - Out of range (b >= NBANK): DOUT <= OOR_DATA, go to DONE.
  - Otherwise: BANK_CS[b] <= 1, BANK_ADDR slice b <= local address, go to GUARD.
- **GUARD:** one cycle. BANK_OK is ignored here to reject a stale OK from the previous address. Clear the timeout counter, go to WAIT.
- **WAIT:**
  - BANK_OK[b]=1: DOUT <= BANK_DOUT slice b, update the cache (address and data, valid=1), drop CS, go to DONE.
  - Else, when the counter equals TIMEOUT-1 (TIMEOUT != 0): DOUT <= OOR_DATA, set TIMEOUT_ERR, drop CS, go to DONE. The cache is not updated.
  - Otherwise the counter increments.
- **DONE:** VALID=1 for this cycle, go to IDLE. RD is not sampled in DONE, so a still-high RD starts a new access one cycle later.
- **Held addresses:** non-selected BANK_ADDR slices keep their last value at all times. The selected slice also holds after CS drops.
- **Ignored requests:** RD while BUSY is ignored, and ADDR changes mid-access are ignored.
- **Simultaneous OK and timeout terminal count:** OK wins. The data is returned and TIMEOUT_ERR is not set.
- **Counter width:** clog2(TIMEOUT+1). It never wraps because it is cleared in GUARD.

## Timing
- RD sampled high in IDLE at edge 0.
  - Hit or out-of-range: VALID high in cycle 1, latency 2 edges to IDLE.
  - Bank access: CS high from cycle 1. GUARD is cycle 1. OK is first sampled at edge 2. If OK is seen at edge k, VALID is high in cycle k+1 and CS is low from k+1.
  - Minimum bank latency: VALID in cycle 3.
  - Timeout: VALID in cycle 2+TIMEOUT.
- BUSY = (state != IDLE).
- Reset values: DOUT=0, VALID=0, BUSY=0, TIMEOUT_ERR=0, BANK_CS=0, all BANK_ADDR=0, cache invalid, state IDLE.
- RESET asserted mid-access clears everything immediately. No VALID is produced for the aborted access.

## Structure
- Package raizing_snd_pkg holds:
  - the state enum {IDLE, GUARD, WAIT, DONE};
  - a clog2 helper function.
- No sub-module; a single module is natural.

## Test plan
- Reset: RESET pulsed mid-WAIT -> all outputs 0 within the same cycle; no VALID; TIMEOUT_ERR=0.
- Bank hit path (defaults): ADDR=24'h40_1234, BANK_OK[1] raised 4 cycles after CS with BANK_DOUT slice1=8'hA5.
  - BANK_CS=3'b010 and BANK_ADDR slice1=22'h001234.
  - DOUT=8'hA5 with a single VALID.
  - Slices 0 and 2 unchanged.
- Stale OK: BANK_OK[0] tied high, ADDR=24'h00_0010 -> CS in cycles 1-2, VALID in cycle 3 (GUARD honoured).
- Out of range: ADDR=24'hC0_0000 -> no CS, DOUT=8'h00, VALID in cycle 1, TIMEOUT_ERR stays 0.
- Timeout: TIMEOUT=8, BANK_OK never raised.
  - VALID in cycle 10, DOUT=OOR_DATA, TIMEOUT_ERR=1 and sticky.
  - A next request to the same address goes to SDRAM again (not cached).
- Cache and back-to-back:
  - Read 24'h80_0005 -> 8'h3C.
  - RD held high -> the second access starts after DONE and is a hit: no CS, DOUT=8'h3C, VALID 2 cycles after the first VALID.
  - OK and the terminal count in the same cycle -> data returned, TIMEOUT_ERR=0.
